// File: rtl/mem_resp_demux.sv
// rtl/mem_resp_demux.sv - memory read handshake with response steering into IR and/or MDR.
// Optional read timeout enabled by defining MEM_TIMEOUT_EN.
module mem_resp_demux #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_dst,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] ir_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              done,
  output logic              err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] DST_IR   = 2'd0;
  localparam logic [1:0] DST_MDR  = 2'd1;
  localparam logic [1:0] DST_BOTH = 2'd2;

  logic [0:0] state;
  logic [1:0] dst_q;
  logic       expire;

  assign req_ready = (state == S_IDLE);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // An ack on the expiry edge still completes normally.
  assign expire = (state == S_WAIT) && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state == S_IDLE) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      dst_q  <= 2'd0;
      ir_q   <= '0;
      mdr_q  <= '0;
      mem_rd <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            dst_q  <= req_dst;
            mem_rd <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (dst_q == DST_IR || dst_q == DST_BOTH) begin
              ir_q <= mem_dout;
            end
            if (dst_q == DST_MDR || dst_q == DST_BOTH) begin
              mdr_q <= mem_dout;
            end
            done   <= 1'b1;
            mem_rd <= 1'b0;
            state  <= S_IDLE;
          end else if (expire) begin
            mem_rd <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_resp_demux.md
Name: mem_resp_demux

Overview:
- Return-path counterpart to the datapath's 2:1 select muxes; together with the mux steering a source onto the memory address, it forms the memory access path of the multi-cycle CPU.
- The mux steers one of several sources onto a shared bus. This block takes the single memory read-data bus and routes each response into the selected destination register: Instruction Register (IR), Memory Data Register (MDR), both, or none.
- Owns the read handshake with memory: issues the read strobe, waits for acknowledge, captures the data, and reports done or timeout to the control FSM.

Parameters:
- DATA_W, 32, width of memory data, IR and MDR.
- TIMEOUT, 15, maximum WAIT cycles before abort (used only with MEM_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  control FSM requests a memory read.
- req_ready  out  1  block can accept a request.
- req_dst  in  2  destination, sampled on accept: 0=IR, 1=MDR, 2=IR and MDR, 3=discard.
- mem_rd  out  1  read strobe to memory.
- mem_ack  in  1  memory data valid this cycle.
- mem_dout  in  DATA_W  memory read data.
- ir_q  out  DATA_W  instruction register.
- mdr_q  out  DATA_W  memory data register.
- done  out  1  one-cycle pulse: transaction completed.
- err  out  1  one-cycle pulse: transaction aborted by timeout.

Behaviour:
- Reset:
  - Applied on a clk edge with rst_n=0. Also applies mid-transaction.
  - State goes to IDLE.
  - ir_q=0, mdr_q=0, mem_rd=0, done=0, err=0.
  - The destination latch and timeout counter are cleared.
- States: IDLE, WAIT.
- IDLE:
  - req_ready=1, mem_rd=0.
  - On req_valid=1 at an edge: latch req_dst, clear the counter, go to WAIT.
  - mem_ack in IDLE is ignored; no register changes.
- WAIT:
  - req_ready=0, mem_rd=1 (registered, held continuously until exit).
  - On mem_ack=1 at an edge, capture mem_dout into the latched destination at that same edge:
    - dst 0 updates IR only.
    - dst 1 updates MDR only.
    - dst 2 updates both.
    - dst 3 updates neither.
  - After the capture: go to IDLE and set done=1 for exactly the next cycle.
- Latency:
  - Request accepted at edge N.
  - mem_rd high from cycle N+1.
  - Ack sampled at edge M: register updated at M; done, req_ready=1 and mem_rd=0 all visible in cycle M+1.
  - Minimum turnaround: ack at N+1 gives done in cycle N+2.
- Back-to-back: a new request may be accepted in the same cycle done is high; done and the new accept are independent.
- Destination registers hold their value across all other cycles.
- Unselected destinations are never written, including on timeout and on the discard code.
- req_dst changes after accept have no effect on the transaction in flight.
- Reset during WAIT:
  - Abandons the transaction; mem_rd is low the following cycle.
  - No done and no err pulse.
  - A late mem_ack arriving after reset is ignored, since the block is in IDLE.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each cycle in WAIT.
  - If no ack has arrived by the edge at which the counter equals TIMEOUT-1: go to IDLE, leave registers unchanged, pulse err for the next cycle.
  - If mem_ack coincides with that edge, the ack wins: normal capture and done, no err.
- Not defined:
  - WAIT persists indefinitely until mem_ack.
  - err is tied to 0.
  - No counter logic is synthesized.

Test Plan:
1. Reset then IR fetch: rst_n=0 for 2 cycles; req dst=0; ack after 3 WAIT cycles with mem_dout=0x8C220004 -> ir_q=0x8C220004, mdr_q=0, done pulses 1 cycle, mem_rd high exactly 3 cycles.
2. MDR and both: dst=1 with data 0x0000ABCD -> mdr_q=0x0000ABCD, ir_q unchanged; then dst=2 with 0x12345678 -> both registers = 0x12345678.
3. Discard and stray ack: dst=3 with data 0xFFFFFFFF -> both registers unchanged, done pulses; mem_ack=1 while IDLE -> no register change, no done.
4. Back-to-back: ack in the first WAIT cycle, new req_valid held high -> second request accepted in the done cycle; mem_rd deasserted for exactly one cycle between transactions.
5. Timeout with MEM_TIMEOUT_EN, TIMEOUT=4: no ack -> err pulses in cycle N+5, mem_rd high 4 cycles, registers unchanged. Ack on the 4th WAIT cycle -> done, no err. Without the macro: no ack for 100 cycles -> still in WAIT, err=0.
6. Reset mid-WAIT: rst_n=0 in the 2nd WAIT cycle, then ack -> mem_rd=0 next cycle, ir_q=mdr_q=0, no done, no err, req_ready=1 after release.
